cgp_cmp_sweep_checker: RTL

- Exhaustive driver and checker for the 4-operand approximate sum comparators in the AxLibrary. Those circuits compute out = (a+b) > (c+d).
- Sweeps every operand combination into the device under test (DUT), samples its 1-bit decision, and compares it against an exact reference.
- Accumulates false-positive and false-negative counts for characterising library entries in hardware.
- Sits on the opposite side of the comparator interface: it drives the DUT operand buses and consumes the DUT decision output.

---
 rtl/cgp_cmp_sweep_checker.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/cgp_cmp_sweep_checker.sv
// Exhaustive sweep driver/checker for 4-operand sum comparators: out = (a+b) > (c+d).
// Optional macro CGP_SWEEP_FIRST_FAIL_EN adds first_fail / first_fail_vec capture.
module cgp_cmp_sweep_checker #(
   parameter int W       = 3,
   parameter int DUT_LAT = 0,
   parameter int CW      = 4*W+1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic [W-1:0]  input_a,
   output logic [W-1:0]  input_b,
   output logic [W-1:0]  input_c,
   output logic [W-1:0]  input_d,
   input  logic          dut_out,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] vec_count,
   output logic [CW-1:0] fp_count,
   output logic [CW-1:0] fn_count,
   output logic [CW-1:0] err_count
`ifdef CGP_SWEEP_FIRST_FAIL_EN
   ,
   output logic            first_fail,
   output logic [4*W-1:0]  first_fail_vec
`endif
);

   localparam int IW  = 4*W;
   localparam int DCW = (DUT_LAT > 1) ? $clog2(DUT_LAT+1) : 1;
   localparam logic [IW-1:0]  IDX_MAX    = '1;
   localparam logic [IW-1:0]  IDX_ONE    = IW'(1);
   localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
   localparam logic [DCW-1:0] DRAIN_ONE  = DCW'(1);
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'((DUT_LAT > 0) ? DUT_LAT-1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   idx;
   logic [DCW-1:0]  drain_cnt;
   logic            launch;
   logic [W:0]      sum_ab, sum_cd;
   logic            exp_in, vld_in;
   logic            exp_d, vld_d;
   logic            mism;

   assign launch = start && (state == S_IDLE || state == S_DONE);

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_SWEEP;
         S_SWEEP: if (idx == IDX_MAX) state_nxt = (DUT_LAT > 0) ? S_DRAIN : S_DONE;
         S_DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = S_DONE;
         S_DONE:  state_nxt = start ? S_SWEEP : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state == S_SWEEP) || (state == S_DRAIN);
      done   = (state == S_DONE);
      vld_in = (state == S_SWEEP);
   end

   // ---------------- vector index / drain timer ----------------
   always_ff @(posedge clk) begin
      if (!rst_n)                               idx <= '0;
      else if (launch)                          idx <= '0;
      else if (state == S_SWEEP && idx != IDX_MAX) idx <= idx + IDX_ONE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || state != S_DRAIN) drain_cnt <= '0;
      else                            drain_cnt <= drain_cnt + DRAIN_ONE;
   end

   assign {input_a, input_b, input_c, input_d} = idx;

   // Exact reference; W+1-bit sums cannot overflow, ties give 0.
   assign sum_ab = {1'b0, input_a} + {1'b0, input_b};
   assign sum_cd = {1'b0, input_c} + {1'b0, input_d};
   assign exp_in = (sum_ab > sum_cd);

   // ---------------- alignment pipe matching the DUT latency ----------------
`ifdef CGP_SWEEP_FIRST_FAIL_EN
   logic [IW-1:0] idx_d;
`endif

   generate
      if (DUT_LAT == 0) begin : g_nolat
         assign vld_d = vld_in;
         assign exp_d = exp_in;
`ifdef CGP_SWEEP_FIRST_FAIL_EN
         assign idx_d = idx;
`endif
      end else begin : g_lat
         logic [DUT_LAT:1] vld_pipe;
         logic [DUT_LAT:1] exp_pipe;
`ifdef CGP_SWEEP_FIRST_FAIL_EN
         logic [DUT_LAT:1][IW-1:0] idx_pipe;
`endif
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               vld_pipe <= '0;
               exp_pipe <= '0;
`ifdef CGP_SWEEP_FIRST_FAIL_EN
               idx_pipe <= '0;
`endif
            end else begin
               vld_pipe[1] <= vld_in;
               exp_pipe[1] <= exp_in;
`ifdef CGP_SWEEP_FIRST_FAIL_EN
               idx_pipe[1] <= idx;
`endif
               for (int i = 2; i <= DUT_LAT; i++) begin
                  vld_pipe[i] <= vld_pipe[i-1];
                  exp_pipe[i] <= exp_pipe[i-1];
`ifdef CGP_SWEEP_FIRST_FAIL_EN
                  idx_pipe[i] <= idx_pipe[i-1];
`endif
               end
            end
         end
         assign vld_d = vld_pipe[DUT_LAT];
         assign exp_d = exp_pipe[DUT_LAT];
`ifdef CGP_SWEEP_FIRST_FAIL_EN
         assign idx_d = idx_pipe[DUT_LAT];
`endif
      end
   endgenerate

   // dut_out is only looked at under vld_d, so X elsewhere is harmless.
   assign mism = vld_d && (dut_out != exp_d);

   // ---------------- counters ----------------
   always_ff @(posedge clk) begin
      if (!rst_n || launch) begin
         vec_count <= '0;
         fp_count  <= '0;
         fn_count  <= '0;
         err_count <= '0;
      end else if (vld_d) begin
         vec_count <= vec_count + CNT_ONE;
         if (mism) begin
            err_count <= err_count + CNT_ONE;
            if (dut_out) fp_count <= fp_count + CNT_ONE;
            else         fn_count <= fn_count + CNT_ONE;
         end
      end
   end

`ifdef CGP_SWEEP_FIRST_FAIL_EN
   always_ff @(posedge clk) begin
      if (!rst_n || launch) begin
         first_fail     <= 1'b0;
         first_fail_vec <= '0;
      end else if (mism && !first_fail) begin
         first_fail     <= 1'b1;
         first_fail_vec <= idx_d;
      end
   end
`endif

endmodule
